// File: rtl/xor_sched_if.sv
// Request/grant/result bundle for the two-requester bit-serial XOR scheduler.
interface xor_sched_if #(
    parameter int WIDTH = 16
);
    logic             req_0;
    logic             req_1;
    logic [WIDTH-1:0] a_0;
    logic [WIDTH-1:0] b_0;
    logic [WIDTH-1:0] a_1;
    logic [WIDTH-1:0] b_1;
    logic             op_0;
    logic             op_1;
    logic             gnt_0;
    logic             gnt_1;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             result_id;

    modport master (
        output req_0, req_1, a_0, b_0, a_1, b_1, op_0, op_1,
        input  gnt_0, gnt_1, busy, done, result, result_id
    );

    modport slave (
        input  req_0, req_1, a_0, b_0, a_1, b_1, op_0, op_1,
        output gnt_0, gnt_1, busy, done, result, result_id
    );
endinterface

// File: rtl/xor_sched.sv
// Round-robin two-requester scheduler feeding one shared 1-bit XOR stage, LSB first.
// Define XOR_SCHED_XNOR_EN to honour the per-request op select (XNOR when op=1).
//
// state | meaning
// IDLE  | waiting for a request; arbitrates and captures operands
// SHIFT | one result bit per edge, WIDTH edges
// DONE  | done pulse cycle; returns to IDLE next edge
module xor_sched #(
    parameter int WIDTH = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    xor_sched_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic [WIDTH-1:0] a_r, a_nx, b_r, b_nx, sr, sr_nx, res_nx;
    logic             last, last_nx, id_r, id_nx;
    logic             gnt0_nx, gnt1_nx, busy_nx, done_nx, resid_nx;
    logic             win, stage_bit;

`ifdef XOR_SCHED_XNOR_EN
    logic op_r, op_nx;
    assign stage_bit = a_r[0] ^ b_r[0] ^ op_r;
`else
    logic unused_op;
    assign unused_op = &{1'b0, bus.op_0, bus.op_1};
    assign stage_bit = a_r[0] ^ b_r[0];
`endif

    // Contention goes to whoever was not granted last; a lone requester always wins.
    assign win = (bus.req_0 && bus.req_1) ? ~last : bus.req_1;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        a_nx     = a_r;
        b_nx     = b_r;
        sr_nx    = sr;
        last_nx  = last;
        id_nx    = id_r;
        gnt0_nx  = 1'b0;
        gnt1_nx  = 1'b0;
        busy_nx  = bus.busy;
        done_nx  = 1'b0;
        res_nx   = bus.result;
        resid_nx = bus.result_id;
`ifdef XOR_SCHED_XNOR_EN
        op_nx    = op_r;
`endif
        case (state)
            IDLE: begin
                busy_nx = 1'b0;
                if (bus.req_0 || bus.req_1) begin
                    a_nx     = win ? bus.a_1 : bus.a_0;
                    b_nx     = win ? bus.b_1 : bus.b_0;
`ifdef XOR_SCHED_XNOR_EN
                    op_nx    = win ? bus.op_1 : bus.op_0;
`endif
                    cnt_nx   = '0;
                    last_nx  = win;
                    id_nx    = win;
                    gnt0_nx  = ~win;
                    gnt1_nx  = win;
                    busy_nx  = 1'b1;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                a_nx   = a_r >> 1;
                b_nx   = b_r >> 1;
                sr_nx  = sr >> 1;
                sr_nx[WIDTH-1] = stage_bit;
                cnt_nx = cnt + 1'b1;
                if (cnt == LAST_BIT) begin
                    res_nx   = sr_nx;
                    resid_nx = id_r;
                    done_nx  = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE: begin
                busy_nx  = 1'b0;
                state_nx = IDLE;
            end
            default: begin
                busy_nx  = 1'b0;
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= IDLE;
            cnt           <= '0;
            a_r           <= '0;
            b_r           <= '0;
            sr            <= '0;
            last          <= 1'b1;
            id_r          <= 1'b0;
            bus.gnt_0     <= 1'b0;
            bus.gnt_1     <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.result    <= '0;
            bus.result_id <= 1'b0;
`ifdef XOR_SCHED_XNOR_EN
            op_r          <= 1'b0;
`endif
        end else begin
            state         <= state_nx;
            cnt           <= cnt_nx;
            a_r           <= a_nx;
            b_r           <= b_nx;
            sr            <= sr_nx;
            last          <= last_nx;
            id_r          <= id_nx;
            bus.gnt_0     <= gnt0_nx;
            bus.gnt_1     <= gnt1_nx;
            bus.busy      <= busy_nx;
            bus.done      <= done_nx;
            bus.result    <= res_nx;
            bus.result_id <= resid_nx;
`ifdef XOR_SCHED_XNOR_EN
            op_r          <= op_nx;
`endif
        end
    end
endmodule

// File: tb/tb_xor_sched.sv
// Directed bench for xor_sched at WIDTH=16; XNOR expectation follows XOR_SCHED_XNOR_EN.
module tb_xor_sched;
    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   failures = 0;

    xor_sched_if #(.WIDTH(16)) bus ();

    xor_sched #(.WIDTH(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Waits for a grant, drops the winner's request, then times grant-to-done.
    task automatic run_op(input string tag, input int exp_id, input logic [15:0] exp_res,
                          input int exp_wait, input bit scramble);
        int n;
        int stray;
        n = 0;
        do begin
            tick();
            n++;
        end while (!(bus.gnt_0 || bus.gnt_1) && n < 40);
        chk({tag, "_gnt_wait"}, n, exp_wait);
        chk({tag, "_gnt_id"}, {30'd0, bus.gnt_1, bus.gnt_0}, (exp_id == 1) ? 32'd2 : 32'd1);
        chk({tag, "_busy_gnt"}, bus.busy, 1);
        if (exp_id == 1) bus.req_1 = 1'b0;
        else             bus.req_0 = 1'b0;
        n = 0;
        stray = 0;
        do begin
            tick();
            n++;
            if (bus.gnt_0 || bus.gnt_1) stray++;
            if (scramble) begin
                bus.a_0  = 16'($urandom);
                bus.b_0  = 16'($urandom);
                bus.op_0 = 1'($urandom);
            end
        end while (!bus.done && n < 40);
        chk({tag, "_stray_gnt"}, stray, 0);
        chk({tag, "_latency"}, n, 16);
        chk({tag, "_result"}, bus.result, exp_res);
        chk({tag, "_result_id"}, bus.result_id, exp_id);
        chk({tag, "_busy_done"}, bus.busy, 1);
        tick();
        chk({tag, "_done_pulse"}, bus.done, 0);
        chk({tag, "_busy_idle"}, bus.busy, 0);
        chk({tag, "_hold"}, bus.result, exp_res);
    endtask

    initial begin
        int dones;
        reset_n  = 1'b0;
        bus.req_0 = 1'b1;
        bus.req_1 = 1'b1;
        bus.a_0  = 16'h00FF;
        bus.b_0  = 16'h0F0F;
        bus.a_1  = 16'h1234;
        bus.b_1  = 16'hFFFF;
        bus.op_0 = 1'b0;
        bus.op_1 = 1'b0;

        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_gnt_0", bus.gnt_0, 0);
            chk("rst_gnt_1", bus.gnt_1, 0);
            chk("rst_busy", bus.busy, 0);
            chk("rst_done", bus.done, 0);
            chk("rst_result", bus.result, 0);
            chk("rst_result_id", bus.result_id, 0);
        end
        reset_n = 1'b1;

        // Contention after reset: 0 first, then the held req_1.
        run_op("cont_a", 0, 16'h0FF0, 1, 1'b0);
        run_op("cont_b", 1, 16'hEDCB, 1, 1'b0);

        bus.req_0 = 1'b1;
        bus.req_1 = 1'b1;
        run_op("cont_rep_a", 0, 16'h0FF0, 1, 1'b0);
        run_op("cont_rep_b", 1, 16'hEDCB, 1, 1'b0);

        // Lone req_1 wins even though it was granted last.
        bus.op_1 = 1'b1;
        bus.a_1  = 16'hAAAA;
        bus.b_1  = 16'hAAAA;
        bus.req_1 = 1'b1;
`ifdef XOR_SCHED_XNOR_EN
        run_op("xnor", 1, 16'hFFFF, 1, 1'b0);
`else
        run_op("xnor", 1, 16'h0000, 1, 1'b0);
`endif
        bus.op_1 = 1'b0;

        bus.a_0  = 16'h00FF;
        bus.b_0  = 16'h0F0F;
        bus.op_0 = 1'b0;
        bus.req_0 = 1'b1;
        run_op("stable", 0, 16'h0FF0, 1, 1'b1);

        bus.a_0  = 16'h1234;
        bus.b_0  = 16'h5678;
        bus.op_0 = 1'b0;
        bus.req_0 = 1'b1;
        tick();
        chk("midrst_gnt", bus.gnt_0, 1);
        bus.req_0 = 1'b0;
        repeat (8) tick();
        chk("midrst_busy_pre", bus.busy, 1);
        reset_n = 1'b0;
        tick();
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_done", bus.done, 0);
        chk("midrst_result", bus.result, 0);
        reset_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.done || bus.busy) dones++;
        end
        chk("midrst_no_done", dones, 0);

        bus.a_0 = 16'hFFFF;
        bus.b_0 = 16'h0001;
        bus.req_0 = 1'b1;
        run_op("after_rst", 0, 16'hFFFE, 1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/xor_sched.md
XOR_SCHED -- requirements
Module: xor_sched

Interface
REQ-001 SHALL have parameter WIDTH, default 16, the operand and result width in bits (legal range 1..32).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have ports req_0 / req_1, input, 1 bit each: level request from requester 0 / 1, held until granted.
REQ-005 SHALL have ports a_0, b_0, a_1, b_1, input, WIDTH each: operands of requester 0 / 1.
REQ-006 SHALL have ports op_0 / op_1, input, 1 bit each: operation select, 0 = XOR, 1 = XNOR (see REQ-022).
REQ-007 SHALL have ports gnt_0 / gnt_1, output, 1 bit each: one-cycle grant pulse; operands were captured.
REQ-008 SHALL have port busy, output, 1 bit: high from the grant cycle through the done cycle.
REQ-009 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have ports result, output, WIDTH, and result_id, output, 1 bit: last completed value and its owner.

Function
REQ-011 SHALL implement FSM states IDLE, SHIFT and DONE, with all outputs registered.
REQ-012 IDLE, any req sampled high at edge E0: SHALL latch the winner's a, b and op, clear the bit counter, go to SHIFT, and drive gnt_winner=1 and busy=1 for the cycle after E0.
REQ-013 SHALL process one bit per edge in SHIFT, LSB first, through one shared 1-bit XOR/XNOR stage: edges E1..E(WIDTH) produce bits 0..WIDTH-1 into a shift register.
REQ-014 At edge E(WIDTH) SHALL go to DONE, update result and result_id, and drive done=1 for exactly the one cycle after E(WIDTH).
REQ-015 SHALL leave DONE for IDLE at edge E(WIDTH+1) with busy=0, so the earliest next grant is at edge E(WIDTH+2).
REQ-016 SHALL hold result and result_id stable between done pulses.
REQ-017 Arbitration SHALL be round-robin with a one-bit last-grant pointer: when both request, grant the requester not granted last; a single requester always wins.
REQ-018 SHALL ignore req while busy (no queueing); a req still high on return to IDLE is a new request.
REQ-019 SHALL ignore operand or op changes after the capture edge.
REQ-020 WIDTH=1 SHALL give one SHIFT cycle, with done following the grant cycle by exactly one cycle.

Reset
REQ-021 When reset_n is low at a rising edge, from any state including mid-SHIFT, SHALL enter IDLE with:
- gnt_0, gnt_1, busy, done, result_id = 0 and result = 0.
- last-grant pointer set so requester 0 wins the first contention.
- bit counter cleared and any in-flight operation discarded without a done pulse.

Configuration
REQ-022 Macro XOR_SCHED_XNOR_EN controls the XNOR option:
- Defined: the latched op selects XOR (0) or XNOR (1) per request.
- Undefined: op_0 and op_1 remain ports but are ignored, and the shared stage is XOR only.

Verification (WIDTH=16)
REQ-023 Reset: hold reset_n=0 for 2 cycles with req_0=req_1=1 -> all outputs 0 and no gnt while reset_n=0.
REQ-024 Single request: req_0=1, a_0=0x00FF, b_0=0x0F0F, op_0=0 -> gnt_0 pulse at E0+1; done at E0+16 with result=0x0FF0, result_id=0.
REQ-025 Contention: req_0 and req_1 rise together after reset, a_1=0x1234, b_1=0xFFFF -> gnt_0 first; gnt_1 at E(18); second done gives result=0xEDCB, result_id=1; repeating the contention then grants 0.
REQ-026 XNOR: op_1=1, a_1=b_1=0xAAAA -> result 0xFFFF with XOR_SCHED_XNOR_EN defined, 0x0000 without it.
REQ-027 Reset mid-operation: pulse reset_n=0 after bit 8 -> busy=0 and no done; a following req_0 with a_0=0xFFFF, b_0=0x0001 gives result=0xFFFE.
REQ-028 Operand stability: change a_0 every cycle after gnt_0 -> result matches operands captured at E0.
